// File: rtl/conv_pre_pkg.sv
// Shared definitions for the skewed-feed front end: FSM encoding, lane default, flag payload.
package conv_pre_pkg;

  localparam int unsigned LANE_NUM_DEF = 9;
  localparam int unsigned FLAG_W       = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    FLUSH = ST_FLUSH,
    DONE  = ST_DONE
  } state_e;

  // One delay-line slot: beat valid plus last-beat marker.
  typedef struct packed {
    logic last;
    logic valid;
  } flag_t;

endpackage

// File: rtl/skew_flag_line.sv
// Delay line carrying {last, valid} through DEPTH registered stages; stage i is the input delayed i+1 cycles.
module skew_flag_line
  import conv_pre_pkg::*;
#(
  parameter int unsigned DEPTH = LANE_NUM_DEF - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  flag_t            flag_in,
  output logic [DEPTH-1:0] valid_out,
  output logic             last_out
);

  flag_t [DEPTH-1:0] stage_q;
  flag_t [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = flag_in;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    valid_out = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_out[i] = stage_q[i].valid;
    end
    last_out = stage_q[DEPTH-1].last;
  end

endmodule

// File: rtl/skew_feed_ctrl.sv
// Tile feed controller: accepts cfg_len beats, produces per-lane skewed valids,
// flushes the skew pipeline and pulses done.
module skew_feed_ctrl
  import conv_pre_pkg::*;
#(
  parameter int unsigned LANE_NUM  = LANE_NUM_DEF,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_len,
  input  logic                 abort,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 feed_zero,
  output logic [LANE_NUM-1:0]  lane_valid,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err_len
);

  localparam int unsigned DEPTH   = LANE_NUM - 1;
  localparam int unsigned FLUSH_W = $clog2(LANE_NUM);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic                 err_len_q, err_len_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 at_end;
  logic                 last_beat;
  flag_t                flag_in;
  logic [DEPTH-1:0]     skew_valid;
  logic                 skew_last;

  // Handshake; abort blocks acceptance so it never coincides with a last beat.
  always_comb begin
    s_ready       = (state_q == LOAD) && !abort;
    accept        = s_valid && s_ready;
    feed_zero     = !accept;
    at_end        = (cnt_q == (len_q - CNT_WIDTH'(1)));
    last_beat     = accept && (at_end || s_last);
    flag_in.valid = accept;
    flag_in.last  = last_beat;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    flush_cnt_d = '0;
    err_len_d   = err_len_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_len_d = 1'b0;
          cnt_d     = '0;
          if (cfg_len != '0) begin
            len_d   = cfg_len;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = FLUSH;
        end else if (accept) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (last_beat) begin
            state_d = FLUSH;
            // Early s_last or missing s_last on the final counted beat.
            if (at_end != s_last) begin
              err_len_d = 1'b1;
            end
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_W'(LANE_NUM - 2)) begin
          state_d = DONE;
        end else begin
          flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      flush_cnt_q <= '0;
      err_len_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      flush_cnt_q <= flush_cnt_d;
      err_len_q   <= err_len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  skew_flag_line #(
    .DEPTH(DEPTH)
  ) u_skew_flag_line (
    .clk      (clk),
    .rst      (rst),
    .flag_in  (flag_in),
    .valid_out(skew_valid),
    .last_out (skew_last)
  );

  always_comb begin
    lane_valid = {skew_valid, accept};
    out_last   = skew_last;
    busy       = busy_q;
    done       = done_q;
    err_len    = err_len_q;
  end

endmodule

// File: tb/tb_skew_feed_ctrl.sv
// Scoreboard bench for skew_feed_ctrl: stimulus queues expected lane/last/done events, a monitor checks them.
module tb_skew_feed_ctrl;

  localparam int unsigned LN  = 9;
  localparam int unsigned CW  = 16;
  localparam int          BIG = 32'h3fff_ffff;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_len;
  logic          abort;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          feed_zero;
  logic [LN-1:0] lane_valid;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err_len;

  skew_feed_ctrl #(
    .LANE_NUM (LN),
    .CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .feed_zero (feed_zero),
    .lane_valid(lane_valid),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    bit e;
  } done_t;

  int    lv_q[LN][$];
  int    last_q[$];
  done_t done_q[$];
  done_t d_pop;
  int    n_pass  = 0;
  int    n_total = 0;
  bit    mon_en  = 1'b0;
  int    t;
  int    lim;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue lane arrivals for a beat accepted in cycle bt, dropping anything at or after cycle lmt.
  task automatic push_beat(input int bt, input int lmt, input bit is_last);
    for (int k = 0; k < LN; k++) begin
      if (bt + k < lmt) lv_q[k].push_back(bt + k);
    end
    if (is_last && (bt + LN - 1 < lmt)) last_q.push_back(bt + LN - 1);
  endtask

  task automatic drive_beat(input bit v, input bit l, input bit is_last, input int lmt);
    s_valid = v;
    s_last  = l;
    #1;
    chk("feed_zero", feed_zero, !v);
    if (v) push_beat(cyc, lmt, is_last);
    step();
  endtask

  task automatic start_tile(input int n);
    cfg_len = CW'(n);
    start   = 1'b1;
    step();
    start = 1'b0;
    chk("s_ready_load", s_ready, 1);
    chk("busy_load", busy, 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 64 && busy; n++) step();
    chk("idle_timeout", busy, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < LN; k++) begin
        if (lane_valid[k]) begin
          if (lv_q[k].size() == 0) chk($sformatf("lane%0d_unexpected", k), cyc, -1);
          else chk($sformatf("lane%0d_time", k), cyc, lv_q[k].pop_front());
        end else if (lv_q[k].size() != 0 && lv_q[k][0] < cyc) begin
          chk($sformatf("lane%0d_missing", k), -1, lv_q[k].pop_front());
        end
      end
      if (out_last) begin
        if (last_q.size() == 0) chk("out_last_unexpected", cyc, -1);
        else chk("out_last_time", cyc, last_q.pop_front());
      end else if (last_q.size() != 0 && last_q[0] < cyc) begin
        chk("out_last_missing", -1, last_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", cyc, -1);
        else begin
          d_pop = done_q.pop_front();
          chk("done_time", cyc, d_pop.c);
          chk("done_err_len", err_len, int'(d_pop.e));
        end
      end else if (done_q.size() != 0 && done_q[0].c < cyc) begin
        d_pop = done_q.pop_front();
        chk("done_missing", -1, d_pop.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_last = 1'b0; cfg_len = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_feed_zero", feed_zero, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_lane_valid", int'(lane_valid), 0);
    chk("rst_err_len", err_len, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic tile of 4 beats
    start_tile(4);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        t = cyc;
        done_q.push_back('{c: t + LN, e: 1'b0});
      end
      drive_beat(1'b1, i == 3, i == 3, BIG);
    end
    s_valid = 1'b0; s_last = 1'b0;
    wait_idle();
    chk("basic_err_len", err_len, 0);

    // Bubbles: 1,0,1,0,1 with cfg_len=3
    start_tile(3);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        t = cyc;
        done_q.push_back('{c: t + LN, e: 1'b0});
      end
      drive_beat(i % 2 == 0, i == 4, i == 4, BIG);
    end
    s_valid = 1'b0; s_last = 1'b0;
    wait_idle();

    // Zero-length tile
    cfg_len = '0;
    start = 1'b1;
    done_q.push_back('{c: cyc + 1, e: 1'b0});
    step();
    start = 1'b0;
    chk("zero_busy_on", busy, 1);
    chk("zero_s_ready", s_ready, 0);
    step();
    chk("zero_busy_off", busy, 0);

    // Early s_last: cfg_len=5, s_last on beat 2
    start_tile(5);
    drive_beat(1'b1, 1'b0, 1'b0, BIG);
    t = cyc;
    done_q.push_back('{c: t + LN, e: 1'b1});
    drive_beat(1'b1, 1'b1, 1'b1, BIG);
    s_valid = 1'b0; s_last = 1'b0;
    chk("mismatch_err_set", err_len, 1);
    chk("mismatch_s_ready", s_ready, 0);
    wait_idle();
    step();
    chk("mismatch_err_sticky", err_len, 1);

    // Abort after 3 beats of a 10-beat tile
    start_tile(10);
    chk("err_cleared_on_start", err_len, 0);
    for (int i = 0; i < 3; i++) drive_beat(1'b1, 1'b0, 1'b0, BIG);
    s_valid = 1'b1;
    abort = 1'b1;
    #1;
    chk("abort_s_ready", s_ready, 0);
    chk("abort_feed_zero", feed_zero, 1);
    done_q.push_back('{c: cyc + LN, e: 1'b0});
    step();
    abort = 1'b0; s_valid = 1'b0;
    wait_idle();
    chk("abort_err_len", err_len, 0);

    // Reset during FLUSH, then a 1-beat tile
    start_tile(2);
    lim = cyc + 5;
    drive_beat(1'b1, 1'b0, 1'b0, lim);
    drive_beat(1'b1, 1'b1, 1'b1, lim);
    s_valid = 1'b0; s_last = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("flush_rst_lane_valid", int'(lane_valid), 0);
    chk("flush_rst_busy", busy, 0);
    chk("flush_rst_done", done, 0);
    chk("flush_rst_out_last", out_last, 0);
    rst = 1'b0;
    start_tile(1);
    done_q.push_back('{c: cyc + LN, e: 1'b0});
    drive_beat(1'b1, 1'b1, 1'b1, BIG);
    s_valid = 1'b0; s_last = 1'b0;
    wait_idle();
    chk("post_rst_err_len", err_len, 0);

    repeat (3) step();
    for (int k = 0; k < LN; k++) chk($sformatf("lane%0d_pending", k), lv_q[k].size(), 0);
    chk("out_last_pending", last_q.size(), 0);
    chk("done_pending", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
